// File: rtl/conv_sched_pkg.sv
// Shared state encoding and sizing helpers for the convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        CLR  = 3'd1,
        ACC  = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned calc_n(input int unsigned sx, input int unsigned sf);
        return sx - sf + 1;
    endfunction

    function automatic int unsigned calc_g(input int unsigned n, input int unsigned p);
        return (n + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Sample-in and result-out handshakes of the convolution sequencer.
interface conv_sched_if #(
    parameter int unsigned SEL_W = 1
);
    logic             x_valid;
    logic             x_ready;
    logic             y_valid;
    logic             y_ready;
    logic [SEL_W-1:0] y_sel;

    modport master (
        output x_valid, y_ready,
        input  x_ready, y_valid, y_sel
    );

    modport slave (
        input  x_valid, y_ready,
        output x_ready, y_valid, y_sel
    );
endinterface

// File: rtl/conv_sched_delay.sv
// Fixed-depth shift register aligning the MAC enable with memory read data.
module conv_sched_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/conv_sched.sv
// Convolution sequencer: loads x, then per output group clears, accumulates,
// waits out the pipeline and streams the lane results one by one.
module conv_sched
    import conv_pkg::*;
#(
    parameter int unsigned SIZE_X  = 32,
    parameter int unsigned SIZE_F  = 10,
    parameter int unsigned P       = 1,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned MAC_LAT = 3,
    localparam int unsigned LX = clog2_min1(SIZE_X),
    localparam int unsigned LF = clog2_min1(SIZE_F)
) (
    input  logic          clk,
    input  logic          reset,
    conv_sched_if.slave   hs,
    output logic          x_wr_en,
    output logic [LX-1:0] x_addr,
    output logic [LF-1:0] f_addr,
    output logic          mac_clear,
    output logic          mac_en,
    output logic          busy,
    output logic          done
);
    localparam int unsigned N        = calc_n(SIZE_X, SIZE_F);
    localparam int unsigned G        = calc_g(N, P);
    localparam int unsigned LAST_L   = N - (G - 1) * P;
    localparam int unsigned WAIT_CYC = MEM_LAT + MAC_LAT;
    localparam int unsigned AW       = LX + 1;
    localparam int unsigned GW       = clog2_min1(G);
    localparam int unsigned WW       = clog2_min1(WAIT_CYC);
    localparam int unsigned LS       = clog2_min1(P);

    state_e          state;
    logic [LX-1:0]   ld_addr;
    logic [AW-1:0]   base;
    logic [AW-1:0]   rd_addr;
    logic [GW-1:0]   g;
    logic [LF-1:0]   k;
    logic [WW-1:0]   w;
    logic [LS-1:0]   j;
    logic [LS-1:0]   last_lane;
    logic            last_group;
    logic            issue;
    logic            done_r;

    always_comb begin
        last_group = (g == GW'(G - 1));
        last_lane  = last_group ? LS'(LAST_L - 1) : LS'(P - 1);
        rd_addr    = base + AW'(k);
        issue      = (state == ACC);
    end

    always_comb begin
        hs.x_ready = (state == LOAD);
        hs.y_valid = (state == OUT);
        hs.y_sel   = j;
        x_wr_en    = (state == LOAD) && hs.x_valid;
        x_addr     = (state == LOAD) ? ld_addr : rd_addr[LX-1:0];
        f_addr     = (state == ACC) ? k : '0;
        mac_clear  = (state == LOAD) || (state == CLR);
        busy       = (state != LOAD);
        done       = done_r;
    end

    // Read base advances by P per group; lane i's +i offset is applied outside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            ld_addr <= '0;
            base    <= '0;
            g       <= '0;
            k       <= '0;
            w       <= '0;
            j       <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (hs.x_valid) begin
                        if (ld_addr == LX'(SIZE_X - 1)) begin
                            ld_addr <= '0;
                            base    <= '0;
                            g       <= '0;
                            state   <= CLR;
                        end else begin
                            ld_addr <= ld_addr + LX'(1);
                        end
                    end
                end
                CLR: begin
                    k     <= '0;
                    state <= ACC;
                end
                ACC: begin
                    if (k == LF'(SIZE_F - 1)) begin
                        k     <= '0;
                        w     <= '0;
                        j     <= '0;
                        state <= (WAIT_CYC == 0) ? OUT : WAIT;
                    end else begin
                        k <= k + LF'(1);
                    end
                end
                WAIT: begin
                    if (w == WW'(WAIT_CYC - 1)) begin
                        j     <= '0;
                        state <= OUT;
                    end else begin
                        w <= w + WW'(1);
                    end
                end
                OUT: begin
                    if (hs.y_ready) begin
                        if (j == last_lane) begin
                            j <= '0;
                            if (last_group) begin
                                done_r <= 1'b1;
                                state  <= LOAD;
                            end else begin
                                g     <= g + GW'(1);
                                base  <= base + AW'(P);
                                state <= CLR;
                            end
                        end else begin
                            j <= j + LS'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    conv_sched_delay #(
        .DEPTH(MEM_LAT)
    ) u_en_dly (
        .clk  (clk),
        .reset(reset),
        .din  (issue),
        .dout (mac_en)
    );
endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched (P=4, MEM_LAT=2): cycle-accurate schedule model plus
// hand-derived totals for each vector.
module tb_conv_sched;
    localparam int SX    = 32;
    localparam int SF    = 10;
    localparam int PP    = 4;
    localparam int ML    = 2;
    localparam int MCL   = 3;
    localparam int N     = SX - SF + 1;
    localparam int G     = (N + PP - 1) / PP;
    localparam int T_OUT = 1 + SF + ML + MCL;
    localparam int LS    = (PP > 1) ? $clog2(PP) : 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       x_wr_en;
    logic [4:0] x_addr;
    logic [3:0] f_addr;
    logic       mac_clear, mac_en, busy, done;

    conv_sched_if #(.SEL_W(LS)) hs ();

    conv_sched #(
        .SIZE_X (SX),
        .SIZE_F (SF),
        .P      (PP),
        .MEM_LAT(ML),
        .MAC_LAT(MCL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hs       (hs),
        .x_wr_en  (x_wr_en),
        .x_addr   (x_addr),
        .f_addr   (f_addr),
        .mac_clear(mac_clear),
        .mac_en   (mac_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int lanes(input int grp);
        return (N - grp * PP < PP) ? N - grp * PP : PP;
    endfunction

    // Model: loading counts samples; computing tracks cycle t within a group
    // and the lane index j once the group is in its output phase.
    bit m_ok = 0;
    int m_mode, m_ld, m_g, m_t, m_j;
    bit m_done;
    int vec_done = 0;

    int cyc = 0;
    int st_wr, st_res, st_done, st_mac, st_max, st_lane3, first_busy, first_yv;

    task automatic clr_stats();
        st_wr = 0; st_res = 0; st_done = 0; st_mac = 0; st_max = 0; st_lane3 = 0;
        first_busy = -1; first_yv = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (x_wr_en) st_wr++;
            if (hs.y_valid && hs.y_ready) begin
                st_res++;
                if (hs.y_sel == 3) st_lane3++;
            end
            if (done) st_done++;
            if (mac_en) st_mac++;
            if (busy && !mac_clear && !hs.y_valid && int'(x_addr) > st_max) st_max = int'(x_addr);
            if (busy && first_busy < 0) first_busy = cyc;
            if (hs.y_valid && first_yv < 0) first_yv = cyc;
        end

        if (m_ok) begin
            if (m_mode == 0) begin
                chk("ld_x_ready", hs.x_ready, 1);
                chk("ld_busy", busy, 0);
                chk("ld_mac_clear", mac_clear, 1);
                chk("ld_mac_en", mac_en, 0);
                chk("ld_y_valid", hs.y_valid, 0);
                chk("ld_x_addr", x_addr, m_ld);
                chk("ld_x_wr_en", x_wr_en, hs.x_valid);
                chk("ld_done", done, m_done);
            end else begin
                chk("cp_x_ready", hs.x_ready, 0);
                chk("cp_busy", busy, 1);
                chk("cp_x_wr_en", x_wr_en, 0);
                chk("cp_done", done, 0);
                chk("cp_mac_clear", mac_clear, (m_t == 0));
                chk("cp_mac_en", mac_en, (m_t >= 1 + ML && m_t <= SF + ML));
                chk("cp_y_valid", hs.y_valid, (m_t >= T_OUT));
                if (m_t == 0) begin
                    chk("clr_x_addr", x_addr, m_g * PP);
                    chk("clr_f_addr", f_addr, 0);
                end else if (m_t <= SF) begin
                    chk("acc_x_addr", x_addr, m_g * PP + m_t - 1);
                    chk("acc_f_addr", f_addr, m_t - 1);
                end
                if (m_t >= T_OUT) chk("out_y_sel", hs.y_sel, m_j);
            end
        end

        if (reset) begin
            m_ok = 1; m_mode = 0; m_ld = 0; m_g = 0; m_t = 0; m_j = 0; m_done = 0;
        end else if (m_ok) begin
            if (m_mode == 0) begin
                m_done = 0;
                if (hs.x_valid) begin
                    m_ld++;
                    if (m_ld == SX) begin
                        m_ld = 0; m_mode = 1; m_g = 0; m_t = 0; m_j = 0;
                    end
                end
            end else if (m_t < T_OUT) begin
                m_t++;
            end else if (hs.y_ready) begin
                m_j++;
                if (m_j == lanes(m_g)) begin
                    m_j = 0;
                    if (m_g < G - 1) begin
                        m_g++; m_t = 0;
                    end else begin
                        m_mode = 0; m_done = 1; vec_done++;
                    end
                end
            end
        end
    end

    // xmode: 0 back-to-back load, 1 toggled load and held high while busy, 2 random.
    // ymode: 0 always ready, 1 random.
    task automatic run_vector(input int xmode, input int ymode, input bit do_stall, input bit do_rst);
        int start, stall_cnt;
        bit stall_arm, rst_arm, rst_now, finished;
        start = vec_done; stall_arm = do_stall; rst_arm = do_rst;
        rst_now = 0; stall_cnt = 0; finished = 0;
        clr_stats();
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(posedge clk); #1;
            if (rst_now) begin
                reset = 1'b0; rst_now = 0;
                chk("rst_x_ready", hs.x_ready, 1);
                chk("rst_mac_en", mac_en, 0);
                chk("rst_mac_clear", mac_clear, 1);
                chk("rst_busy", busy, 0);
                clr_stats();
                start = vec_done;
            end
            if (vec_done != start) begin
                finished = 1; hs.x_valid = 1'b0; hs.y_ready = 1'b0;
            end else begin
                if (rst_arm && busy && f_addr == 6) begin
                    reset = 1'b1; rst_arm = 0; rst_now = 1;
                end
                case (xmode)
                    0: hs.x_valid = !busy;
                    1: hs.x_valid = busy ? 1'b1 : c[0];
                    default: hs.x_valid = 1'($urandom_range(0, 1));
                endcase
                if (stall_arm && hs.y_valid && hs.y_sel == 1) begin
                    stall_cnt = 5; stall_arm = 0;
                end
                if (stall_cnt > 0) begin
                    hs.y_ready = 1'b0; stall_cnt--;
                    chk("stall_y_valid", hs.y_valid, 1);
                    chk("stall_y_sel", hs.y_sel, 1);
                end else begin
                    hs.y_ready = (ymode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
        end
        chk("vector_finished", finished, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hs.x_valid = 1'b0; hs.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x_ready", hs.x_ready, 1);
        chk("reset_x_addr", x_addr, 0);
        chk("reset_f_addr", f_addr, 0);
        chk("reset_mac_clear", mac_clear, 1);
        chk("reset_mac_en", mac_en, 0);
        chk("reset_y_valid", hs.y_valid, 0);
        chk("reset_y_sel", hs.y_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;

        run_vector(0, 0, 0, 0);
        chk("v1_writes", st_wr, 32);
        chk("v1_results", st_res, 23);
        chk("v1_lane3_results", st_lane3, 5);
        chk("v1_done_pulses", st_done, 1);
        chk("v1_mac_en_cycles", st_mac, 60);
        chk("v1_max_read_base", st_max, 29);
        chk("v1_first_y_latency", first_yv - first_busy, 16);

        run_vector(1, 0, 1, 0);
        chk("v2_writes", st_wr, 32);
        chk("v2_results", st_res, 23);
        chk("v2_lane3_results", st_lane3, 5);
        chk("v2_done_pulses", st_done, 1);

        run_vector(2, 1, 0, 1);
        chk("v3_writes", st_wr, 32);
        chk("v3_results", st_res, 23);
        chk("v3_done_pulses", st_done, 1);
        chk("v3_mac_en_cycles", st_mac, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer for the convolution datapath: x sample memory, f coefficient ROM, P parallel MAC lanes, output selection.
- Accepts a full x vector over a valid/ready handshake and drives the memory write strobes.
- Steps through ceil(N/P) output groups, with N = SIZE_X-SIZE_F+1. Per group it drives read addresses, MAC clear/enable and pipeline-latency waits.
- Streams each group's lane results out one at a time over a y valid/ready handshake.

Parameters:
- SIZE_X, 32, x vector length.
- SIZE_F, 10, filter length.
- P, 1, parallel MAC lanes, 1..N.
- MEM_LAT, 1, read latency of x memory and f ROM in cycles.
- MAC_LAT, 3, cycles from the mac_en cycle until that term is visible on the lane accumulator output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block can accept a sample.
- x_wr_en  out  1  x memory write strobe, equal to x_valid & x_ready.
- x_addr  out  LX=$clog2(SIZE_X)  write address during LOAD, group read base during ACC.
- f_addr  out  LF=$clog2(SIZE_F)  coefficient ROM address.
- mac_clear  out  1  clear all lane accumulators.
- mac_en  out  1  accumulate enable to all lanes.
- y_sel  out  max(1,$clog2(P))  lane index for the external output mux.
- y_valid  out  1  selected lane result is valid.
- y_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except LOAD.
- done  out  1  one-cycle pulse after the last output of a vector.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=LOAD, x_ready=1, x_addr=0, f_addr=0, mac_clear=1, mac_en=0, y_sel=0, y_valid=0, busy=0, done=0. All counters are 0.
- Reset asserted mid-operation: abort and return to these values next edge. No output handshake completes in the reset cycle.
- Derived constants: N=SIZE_X-SIZE_F+1. G=ceil(N/P). Lanes in group g: L(g)=min(P, N-g*P).
- LOAD state:
  - x_ready=1. Each x_valid cycle writes the sample at x_addr, then x_addr increments.
  - On the accepted write at x_addr=SIZE_X-1: x_ready drops next cycle, x_addr=0, g=0, go to CLR.
  - A gap in x_valid stalls the load; nothing else happens.
- CLR state (1 cycle): mac_clear=1, mac_en=0, f_addr=0, x_addr=g*P. Then go to ACC.
- ACC state (SIZE_F cycles), for k=0..SIZE_F-1:
  - f_addr=k, x_addr=g*P+k. Lane i adds i externally.
  - mac_clear=0.
  - mac_en is the issue strobe delayed MEM_LAT cycles, so it is asserted for exactly SIZE_F consecutive cycles aligned with the returned data.
  - After k=SIZE_F-1, go to WAIT.
- WAIT state: hold for MEM_LAT+MAC_LAT cycles, counted from the cycle after the last issue, so the final term lands in every lane. Then y_sel=0 and go to OUT.
- OUT state:
  - y_valid=1 with y_sel=j.
  - On y_valid & y_ready: j increments. The next lane shows the following cycle, so one result per cycle while y_ready is held high.
  - After lane L(g)-1 is accepted: y_valid=0.
  - If g<G-1: g++ and go to CLR.
  - Otherwise: done=1 for one cycle, go to LOAD, x_ready=1 next cycle.
- y_ready low holds y_valid and y_sel stable indefinitely.
- Lanes j>=L(g) in a partial last group are never presented.
- x_valid outside LOAD is ignored and x_wr_en=0.
- Address arithmetic: computed in LX+1 bits. Largest read address g*P+P-1+SIZE_F-1 is at most SIZE_X-1 for valid lanes. Invalid lanes of a partial group may read out of range; their results are discarded.
- Total compute cycles per group: 1+SIZE_F+MEM_LAT+MAC_LAT, plus L(g) output cycles when y_ready is held high.

Decomposition:
- Shared package conv_pkg:
  - state enum {LOAD, CLR, ACC, WAIT, OUT}.
  - Functions for N, G and the width clog2 with a minimum of 1.
- One sub-module is natural: conv_sched_delay, a MEM_LAT-deep shift register that aligns mac_en with the issue strobe.
- All other logic (FSM, counters) stays in conv_sched.

Test Plan:
- Defaults with y_ready=1: 32 back-to-back x_valid -> x_wr_en on addresses 0..31, x_ready low from cycle 33. Then 23 groups, each with one mac_clear pulse, mac_en exactly 10 cycles, a 4-cycle wait, one y_valid beat with y_sel=0; done pulses once after the 23rd beat.
- P=4: groups g=0..5 emit y_sel 0..3, except g=5, which emits only 0..2 (23 results total). x_addr bases are 0,4,8,…,20. Maximum valid read address is 31.
- x_valid toggled 1/0 during LOAD plus held high during ACC -> exactly 32 writes, no writes outside LOAD, CLR entered only after address 31.
- y_ready low for 5 cycles in OUT (P=4, lane 1) -> y_valid=1 and y_sel=1 held stable; no extra handshake. On release, lanes 1,2,3 accepted on consecutive cycles.
- reset pulsed during ACC (k=6) -> next cycle state LOAD, x_ready=1, mac_en=0, mac_clear=1. A fresh 32-sample load yields the full 23-result sequence.
- MEM_LAT=2, MAC_LAT=3: mac_en starts 2 cycles after the first issue. y_valid rises 1+10+5 cycles after CLR entry.
